hazard_ctrl: RTL and testbench

- Pipeline control block that drives the write-enable, bubble and flush controls consumed by the PC, IF/ID and ID/EX registers.
- Detects load-use hazards from the ID/EX register contents and handles taken-branch flushes, with programmable stall and flush lengths.
- Also handles external stalls, such as a data memory that is not ready.
- Keeps event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Pipeline hazard control with load-use stalls, branch flushes,
//            external freeze handling and event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             branch_taken,
    input  logic             ext_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] c_RUN   = 2'd0;
    localparam logic [1:0] c_STALL = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    localparam logic [3:0] c_LU_REM  = 4'(LOAD_USE_CYCLES - 1);
    localparam logic [3:0] c_FL_REM  = 4'(FLUSH_CYCLES - 1);
    localparam logic [1:0] c_BR_NEXT = (FLUSH_CYCLES > 1) ? c_FLUSH : c_RUN;
    localparam logic [1:0] c_LU_NEXT = (LOAD_USE_CYCLES > 1) ? c_STALL : c_RUN;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [3:0]       r_rem;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0] w_next_state;
    logic [3:0] w_next_rem;
    logic       w_stall_inc;
    logic       w_flush_inc;
    logic       w_hz;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_hz = idex_memread && (idex_rd != 5'd0) &&
                  ((ifid_use_rs1 && (ifid_rs1 == idex_rd)) ||
                   (ifid_use_rs2 && (ifid_rs2 == idex_rd)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_RUN;
            r_rem       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
            if (w_stall_inc) r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            if (w_flush_inc) r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        case (r_state)
            c_RUN: begin
                if (branch_taken) begin
                    w_flush_inc  = 1'b1;
                    w_next_state = c_BR_NEXT;
                    w_next_rem   = c_FL_REM;
                end else if (!ext_stall && w_hz) begin
                    w_stall_inc  = 1'b1;
                    w_next_state = c_LU_NEXT;
                    w_next_rem   = c_LU_REM;
                end
            end
            c_STALL: begin
                if (branch_taken) begin
                    w_flush_inc  = 1'b1;
                    w_next_state = c_BR_NEXT;
                    w_next_rem   = c_FL_REM;
                end else if (!ext_stall) begin
                    w_stall_inc = 1'b1;
                    w_next_rem  = r_rem - 4'd1;
                    if (r_rem <= 4'd1) w_next_state = c_RUN;
                end
            end
            c_FLUSH: begin
                if (branch_taken) begin
                    w_flush_inc  = 1'b1;
                    w_next_state = c_BR_NEXT;
                    w_next_rem   = c_FL_REM;
                end else if (!ext_stall) begin
                    w_next_rem = r_rem - 4'd1;
                    if (r_rem <= 4'd1) w_next_state = c_RUN;
                end
            end
            default: begin
                w_next_state = c_RUN;
                w_next_rem   = 4'd0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!reset) begin
            case (r_state)
                c_RUN: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (ext_stall) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                    end else if (w_hz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                c_STALL: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = !ext_stall;
                    end
                end
                c_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    if (!branch_taken && ext_stall) pc_write = 1'b0;
                end
                default: begin
                    pc_write = 1'b1;
                end
            endcase
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Vector-table bench for hazard_ctrl across three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam logic [5:0] c_DEF = 6'b110000;
    localparam logic [5:0] c_BUB = 6'b001000;
    localparam logic [5:0] c_FRZ = 6'b000000;
    localparam logic [5:0] c_FL  = 6'b110111;
    localparam logic [5:0] c_FLX = 6'b010111;

    localparam int P_IDLE = 0, P_HZ = 1, P_X0 = 2, P_R2U = 3, P_NOMR = 4, P_HZ2 = 5;

    typedef struct {
        int         sel;
        bit         pre_rst;
        string      name;
        int         pat;
        logic       rst;
        logic       br;
        logic       xs;
        logic [5:0] ctl;
        logic [1:0] st;
        int         sc;
        int         fc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
    logic       ifid_use_rs1, ifid_use_rs2, idex_memread, branch_taken, ext_stall;

    logic [5:0]  a_ctl, b_ctl, c_ctl;
    logic [1:0]  a_st, b_st, c_st;
    logic [2:0]  a_sc, a_fc;
    logic [31:0] b_sc, b_fc, c_sc, c_fc;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_USE_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(3)) u_a (
        .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_write(a_ctl[5]), .ifid_write(a_ctl[4]), .idex_bubble(a_ctl[3]),
        .ifid_flush(a_ctl[2]), .idex_flush(a_ctl[1]), .exmem_flush(a_ctl[0]),
        .state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc));

    hazard_ctrl #(.LOAD_USE_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_write(b_ctl[5]), .ifid_write(b_ctl[4]), .idex_bubble(b_ctl[3]),
        .ifid_flush(b_ctl[2]), .idex_flush(b_ctl[1]), .exmem_flush(b_ctl[0]),
        .state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc));

    hazard_ctrl #(.LOAD_USE_CYCLES(4), .FLUSH_CYCLES(1), .CNT_W(32)) u_c (
        .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .idex_memread(idex_memread), .idex_rd(idex_rd),
        .branch_taken(branch_taken), .ext_stall(ext_stall),
        .pc_write(c_ctl[5]), .ifid_write(c_ctl[4]), .idex_bubble(c_ctl[3]),
        .ifid_flush(c_ctl[2]), .idex_flush(c_ctl[1]), .exmem_flush(c_ctl[0]),
        .state(c_st), .stall_cnt(c_sc), .flush_cnt(c_fc));

    function automatic vec_t mk(input int sel, input bit pre, input string name,
                                input int pat, input logic rst, input logic br,
                                input logic xs, input logic [5:0] ctl,
                                input logic [1:0] st, input int sc, input int fc);
        vec_t v;
        v.sel = sel; v.pre_rst = pre; v.name = name; v.pat = pat;
        v.rst = rst; v.br = br; v.xs = xs; v.ctl = ctl; v.st = st;
        v.sc = sc; v.fc = fc;
        return v;
    endfunction

    task automatic drive_pat(input int pat);
        ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0;
        idex_memread = 1'b0; idex_rd = 5'd0;
        case (pat)
            P_HZ:   begin ifid_rs1 = 5'd5; ifid_use_rs1 = 1'b1; idex_memread = 1'b1; idex_rd = 5'd5; end
            P_X0:   begin ifid_use_rs1 = 1'b1; idex_memread = 1'b1; end
            P_R2U:  begin ifid_rs1 = 5'd3; ifid_use_rs1 = 1'b1; ifid_rs2 = 5'd7;
                          idex_memread = 1'b1; idex_rd = 5'd7; end
            P_NOMR: begin ifid_rs1 = 5'd5; ifid_use_rs1 = 1'b1; idex_rd = 5'd5; end
            P_HZ2:  begin ifid_rs2 = 5'd7; ifid_use_rs2 = 1'b1; idex_memread = 1'b1; idex_rd = 5'd7; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        drive_pat(P_IDLE);
        branch_taken = 1'b0; ext_stall = 1'b0; reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic cmp(input string name, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", name, fld, act, exp);
        end
    endtask

    task automatic check_front();
        vec_t        v;
        logic [5:0]  ctl;
        logic [1:0]  st;
        logic [31:0] sc, fc;
        v = exp_q.pop_front();
        case (v.sel)
            0:       begin ctl = a_ctl; st = a_st; sc = 32'(a_sc); fc = 32'(a_fc); end
            1:       begin ctl = b_ctl; st = b_st; sc = b_sc; fc = b_fc; end
            default: begin ctl = c_ctl; st = c_st; sc = c_sc; fc = c_fc; end
        endcase
        cmp(v.name, "ctl", 32'(ctl), 32'(v.ctl));
        cmp(v.name, "state", 32'(st), 32'(v.st));
        cmp(v.name, "stall_cnt", sc, v.sc);
        cmp(v.name, "flush_cnt", fc, v.fc);
    endtask

    task automatic apply(input vec_t v);
        if (v.pre_rst) do_reset();
        drive_pat(v.pat);
        reset = v.rst; branch_taken = v.br; ext_stall = v.xs;
        exp_q.push_back(v);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // counter values are those visible before the cycle's own clock edge
        tbl.push_back(mk(0, 1, "reset_out",   P_HZ,   1, 0, 0, c_DEF, 0, 0, 0));
        tbl.push_back(mk(0, 0, "load_use",    P_HZ,   0, 0, 0, c_BUB, 0, 0, 0));
        tbl.push_back(mk(0, 0, "after_lu",    P_IDLE, 0, 0, 0, c_DEF, 0, 1, 0));
        tbl.push_back(mk(0, 0, "rd_x0",       P_X0,   0, 0, 0, c_DEF, 0, 1, 0));
        tbl.push_back(mk(0, 0, "rs2_unused",  P_R2U,  0, 0, 0, c_DEF, 0, 1, 0));
        tbl.push_back(mk(0, 0, "no_memread",  P_NOMR, 0, 0, 0, c_DEF, 0, 1, 0));
        tbl.push_back(mk(0, 0, "rs2_hz",      P_HZ2,  0, 0, 0, c_BUB, 0, 1, 0));
        tbl.push_back(mk(0, 0, "ext_over_hz", P_HZ,   0, 0, 1, c_FRZ, 0, 2, 0));
        tbl.push_back(mk(0, 0, "br_over_all", P_HZ,   0, 1, 1, c_FL,  0, 2, 0));
        tbl.push_back(mk(0, 0, "after_br",    P_IDLE, 0, 0, 0, c_DEF, 0, 2, 1));
        tbl.push_back(mk(0, 0, "reset_mid",   P_IDLE, 1, 0, 0, c_DEF, 0, 2, 1));
        tbl.push_back(mk(0, 0, "br_and_hz",   P_HZ,   0, 1, 0, c_FL,  0, 0, 0));
        tbl.push_back(mk(0, 0, "after_brhz",  P_IDLE, 0, 0, 0, c_DEF, 0, 0, 1));
        tbl.push_back(mk(1, 1, "ms_t0",   P_HZ,   0, 0, 0, c_BUB, 0, 0, 0));
        tbl.push_back(mk(1, 0, "ms_t1",   P_IDLE, 0, 0, 0, c_BUB, 1, 1, 0));
        tbl.push_back(mk(1, 0, "ms_t2",   P_IDLE, 0, 0, 0, c_BUB, 1, 2, 0));
        tbl.push_back(mk(1, 0, "ms_end",  P_IDLE, 0, 0, 0, c_DEF, 0, 3, 0));
        tbl.push_back(mk(1, 1, "xs_t0",   P_HZ,   0, 0, 0, c_BUB, 0, 0, 0));
        tbl.push_back(mk(1, 0, "xs_t1",   P_IDLE, 0, 0, 0, c_BUB, 1, 1, 0));
        tbl.push_back(mk(1, 0, "xs_frz",  P_IDLE, 0, 0, 1, c_FRZ, 1, 2, 0));
        tbl.push_back(mk(1, 0, "xs_t2",   P_IDLE, 0, 0, 0, c_BUB, 1, 2, 0));
        tbl.push_back(mk(1, 0, "xs_end",  P_IDLE, 0, 0, 0, c_DEF, 0, 3, 0));
        tbl.push_back(mk(1, 1, "fl_t0",   P_IDLE, 0, 1, 0, c_FL,  0, 0, 0));
        tbl.push_back(mk(1, 0, "fl_t1",   P_IDLE, 0, 1, 0, c_FL,  2, 0, 1));
        tbl.push_back(mk(1, 0, "fl_t2",   P_IDLE, 0, 0, 0, c_FL,  2, 0, 2));
        tbl.push_back(mk(1, 0, "fl_t3",   P_IDLE, 0, 0, 0, c_DEF, 0, 0, 2));
        tbl.push_back(mk(1, 0, "flx_t0",  P_IDLE, 0, 1, 0, c_FL,  0, 0, 2));
        tbl.push_back(mk(1, 0, "flx_frz", P_IDLE, 0, 0, 1, c_FLX, 2, 0, 3));
        tbl.push_back(mk(1, 0, "flx_t1",  P_IDLE, 0, 0, 0, c_FL,  2, 0, 3));
        tbl.push_back(mk(1, 0, "flx_end", P_IDLE, 0, 0, 0, c_DEF, 0, 0, 3));
        tbl.push_back(mk(1, 0, "bs_hz",   P_HZ,   0, 0, 0, c_BUB, 0, 0, 3));
        tbl.push_back(mk(1, 0, "bs_br",   P_IDLE, 0, 1, 0, c_FL,  1, 1, 3));
        tbl.push_back(mk(1, 0, "bs_fl",   P_HZ,   0, 0, 0, c_FL,  2, 1, 4));
        tbl.push_back(mk(1, 0, "bs_end",  P_IDLE, 0, 0, 0, c_DEF, 0, 1, 4));
        tbl.push_back(mk(2, 1, "rs_t0",    P_HZ,   0, 0, 0, c_BUB, 0, 0, 0));
        tbl.push_back(mk(2, 0, "rs_t1",    P_HZ,   0, 0, 0, c_BUB, 1, 1, 0));
        tbl.push_back(mk(2, 0, "rs_rst",   P_HZ,   1, 0, 0, c_DEF, 1, 2, 0));
        tbl.push_back(mk(2, 0, "rs_after", P_IDLE, 0, 0, 0, c_DEF, 0, 0, 0));

        do_reset();
        foreach (tbl[i]) apply(tbl[i]);

        // 3-bit counter on u_a: nine hazards wrap stall_cnt back to 1
        do_reset();
        for (int i = 0; i < 9; i++)
            apply(mk(0, 0, $sformatf("wrap_%0d", i), P_HZ, 0, 0, 0, c_BUB, 0, i % 8, 0));
        apply(mk(0, 0, "wrap_end", P_IDLE, 0, 0, 0, c_DEF, 0, 1, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
